// File: rtl/logo_uart_frame_dumper_pkg.sv
// Shared definitions for the logo frame stream: address width, marker default,
// FSM states and rgb12 <-> UART byte-pair packing.
package logo_uart_frame_dumper_pkg;

    localparam int unsigned AddrW          = 17;
    localparam logic [15:0] HdrWordDefault = 16'hA55A;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StFetch,
        StWait,
        StSendHi,
        StSendLo
    } state_e;

    function automatic logic [7:0] pix_byte_hi(input logic [11:0] rgb);
        return rgb[11:4];
    endfunction

    function automatic logic [7:0] pix_byte_lo(input logic [11:0] rgb);
        return {rgb[3:0], 4'h0};
    endfunction

endpackage

// File: rtl/logo_uart_frame_dumper.sv
// Reads one RGB444 frame from a dualbuf bank and streams it to the UART TX core
// as byte pairs, optionally preceded by a 2-byte marker.
module logo_uart_frame_dumper
    import logo_uart_frame_dumper_pkg::*;
#(
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 240,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned HDR_EN   = 0,
    parameter logic [15:0] HDR_WORD = HdrWordDefault
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             start,
    input  logic             abort,
    input  logic             read_buf_sys,
    output logic             rd_bank,
    output logic             rd_en,
    output logic [AddrW-1:0] rd_addr,
    input  logic [11:0]      rd_data,
    output logic [7:0]       tx_byte,
    output logic             tx_vld,
    input  logic             tx_rdy,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      DEPTH    = WIDTH * HEIGHT;
    localparam int unsigned      WaitW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_LAT - 1);

    state_e             state_q, state_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [11:0]        pix_q, pix_d;
    logic               rd_bank_q, rd_bank_d;
    logic               rd_en_q, rd_en_d;
    logic [AddrW-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_vld_q, tx_vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hs;

    assign hs = tx_vld_q && tx_rdy;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wait_d    = wait_q;
        pix_d     = pix_q;
        rd_bank_d = rd_bank_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        tx_byte_d = tx_byte_q;
        tx_vld_d  = tx_vld_q;
        done_d    = 1'b0;

        // Abort wins over a handshake completing in the same cycle; the pending byte is dropped.
        if (state_q != StIdle && abort) begin
            state_d   = StIdle;
            addr_d    = '0;
            wait_d    = '0;
            rd_addr_d = '0;
            tx_byte_d = '0;
            tx_vld_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        rd_bank_d = read_buf_sys;
                        addr_d    = '0;
                        wait_d    = '0;
                        if (HDR_EN != 0) begin
                            state_d   = StHdrHi;
                            tx_byte_d = HDR_WORD[15:8];
                            tx_vld_d  = 1'b1;
                        end else begin
                            state_d   = StFetch;
                            rd_en_d   = 1'b1;
                            rd_addr_d = '0;
                        end
                    end
                end
                StHdrHi: begin
                    if (hs) begin
                        state_d   = StHdrLo;
                        tx_byte_d = HDR_WORD[7:0];
                    end
                end
                StHdrLo: begin
                    if (hs) begin
                        state_d   = StFetch;
                        tx_vld_d  = 1'b0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q;
                    end
                end
                StFetch: begin
                    state_d = StWait;
                    wait_d  = '0;
                end
                StWait: begin
                    if (wait_q == WaitLast) begin
                        state_d   = StSendHi;
                        wait_d    = '0;
                        pix_d     = rd_data;
                        tx_byte_d = pix_byte_hi(rd_data);
                        tx_vld_d  = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                StSendHi: begin
                    if (hs) begin
                        state_d   = StSendLo;
                        tx_byte_d = pix_byte_lo(pix_q);
                    end
                end
                StSendLo: begin
                    if (hs) begin
                        tx_vld_d = 1'b0;
                        if (addr_q == LastAddr) begin
                            state_d   = StIdle;
                            addr_d    = '0;
                            rd_addr_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            state_d   = StFetch;
                            addr_d    = addr_q + 1'b1;
                            rd_addr_d = addr_q + 1'b1;
                            rd_en_d   = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wait_q    <= '0;
            pix_q     <= '0;
            rd_bank_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tx_byte_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            pix_q     <= pix_d;
            rd_bank_q <= rd_bank_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tx_byte_q <= tx_byte_d;
            tx_vld_q  <= tx_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_bank = rd_bank_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign tx_byte = tx_byte_q;
    assign tx_vld  = tx_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
